mxfp4_dot_ctrl: RTL and testbench
=================================

# mxfp4_dot_ctrl

Sequencer for one `mac_mxfp4` lane that computes an MX-block dot product. It accepts a job descriptor: length, buffer base address and the two E8M0 shared scales. It then streams fp4 weight/activation pairs from a local operand buffer into the MAC, flushes the MAC pipeline and presents the integer accumulator with the combined block exponent on a valid/ready result port. It sits between the tile scheduler (job side) and the operand SRAM plus MAC lane (datapath side).

## Interface
- `ADDR_WIDTH`, 6: operand buffer address width; max job length 2^ADDR_WIDTH.
- `ACC_WIDTH`, 14: width of MAC accumulator and `res_acc`.
- `clk` in 1: single clock, all logic rising-edge.
- `reset` in 1: synchronous, active-high.
- `start_valid` in 1: job descriptor valid.
- `start_ready` out 1: controller idle, can accept a job.
- `len` in ADDR_WIDTH+1: element count, 0..2^ADDR_WIDTH.
- `base_addr` in ADDR_WIDTH: first buffer address.
- `scale_w`, `scale_a` in 8 each: E8M0 shared scales (bias 127, 0xFF = NaN).
- `rd_en` out 1, `rd_addr` out ADDR_WIDTH: buffer read port; data returns next cycle.
- `buf_w`, `buf_a` in 4 each: fp4 (sign, 2b exp, 1b man) read data.
- `mac_en` out 1, `mac_clr` out 1: MAC enable and MAC reset.
- `mac_w`, `mac_a` out 4 each: operands to the MAC.
- `mac_out` in ACC_WIDTH signed: MAC accumulator.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_acc` out ACC_WIDTH signed: dot-product integer.
- `res_exp` out 10 signed: combined block exponent.
- `res_nan` out 1: either scale was 0xFF.
- `busy` out 1: state != IDLE.

## Operation
- States: IDLE, CLEAR, ISSUE, WAIT, FLUSH, RESULT.
- **IDLE**
  - `start_ready` = 1.
  - On `start_valid`, latch `len`, `base_addr` and the scales, then go to CLEAR.
- **CLEAR**
  - `mac_clr` = 1 for exactly one cycle.
  - Element counter `cnt` is cleared.
  - Next state is ISSUE, or RESULT if `len` == 0.
- **ISSUE**
  - `rd_en` = 1 and `rd_addr` = (base + `cnt`) mod 2^ADDR_WIDTH, so addresses wrap.
  - `cnt` increments each cycle.
  - After the read with `cnt` == `len`-1, go to WAIT.
- **WAIT**: one cycle while the last read data returns.
- **FLUSH**
  - One cycle with `mac_en` = 1 and `mac_w` = `mac_a` = 0.
  - This pushes the last registered product into the accumulator.
- **RESULT**
  - `res_valid` = 1 and `res_acc` = `mac_out`; the MAC is quiescent, so the value is stable.
  - Hold all outputs until `res_ready`; on handshake go to IDLE.
- Operand path:
  - `en_d` = `rd_en` delayed one cycle.
  - `mac_en` = `en_d` | (state == FLUSH).
  - `mac_w`/`mac_a` = `buf_w`/`buf_a` when `en_d`, otherwise 0.
- `mac_clr` = `reset` | (state == CLEAR).
- `res_exp` = `scale_w` + `scale_a` − 254, computed at 10-bit signed width.
- `res_nan` = (`scale_w` == 0xFF) | (`scale_a` == 0xFF).
- Accumulator overflow wraps in the MAC; the controller neither detects nor saturates it.
- `start_valid` outside IDLE is ignored, since `start_ready` = 0.

## Timing
- Job accepted at the edge ending cycle T. Then:
  - CLEAR occupies T+1.
  - ISSUE occupies T+2..T+len+1.
  - WAIT occupies T+len+2.
  - FLUSH occupies T+len+3.
  - `res_valid` rises at T+len+4.
  - Latency is len+4 cycles.
- For `len` == 0: `res_valid` rises at T+2 with `res_acc` = 0.
- `mac_en` is high for exactly len+1 consecutive cycles, T+3..T+len+3.
- Back-to-back jobs: with `res_ready` high in the first RESULT cycle, the next `start_valid` is accepted no earlier than the cycle after.
- Reset values:
  - State is IDLE and `start_ready` = 1.
  - All other outputs are 0, except `mac_clr` = 1 while `reset` is high.
- Reset mid-job: abort at the next edge, return to IDLE, drop any pending result, and clear the MAC.

## Test plan
- **Basic dot product**: `len`=4, all w=a=0x3 (value 3 each in MAC integer units), scales 127/127 -> `res_acc`=36, `res_exp`=0, `res_valid` at T+8.
- **Negative and address wrap**: `len`=4, `base_addr`=62, w=0xB, a=0x3 -> `rd_addr` sequence 62, 63, 0, 1; `res_acc`=−36.
- **Long job**: `len`=32, w=a=0x7 -> `res_acc`=4608; `mac_en` high for exactly 33 cycles.
- **Zero length and NaN scale**: `len`=0, `scale_w`=0xFF -> no `rd_en`; `res_acc`=0 and `res_nan`=1 at T+2.
- **Backpressure**: hold `res_ready`=0 for 10 cycles -> `res_*` stable; `start_valid` pulses ignored; job accepted only after the handshake.
- **Reset mid-job**: assert `reset` during ISSUE with cnt=2 -> IDLE next cycle; `res_valid` never rises; a following `len`=1 job with w=a=0x2 gives `res_acc`=4 (no stale sum).

Source files
------------

// File: rtl/mxfp4_dot_ctrl.sv
// Job sequencer for one mac_mxfp4 lane: streams an MX block's fp4 pairs from the
// operand buffer into the MAC, flushes its product stage and returns the accumulator.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for a job descriptor
// CLEAR  | one-cycle MAC clear, element counter reset
// ISSUE  | one buffer read per cycle, base + cnt with address wrap
// WAIT   | last read data returning from the buffer
// FLUSH  | zero operands push the last registered product into acc
// RESULT | accumulator and block exponent held until res_ready
module mxfp4_dot_ctrl #(
   parameter int ADDR_WIDTH = 6,
   parameter int ACC_WIDTH  = 14
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start_valid,
   output logic                        start_ready,
   input  logic [ADDR_WIDTH:0]         len,
   input  logic [ADDR_WIDTH-1:0]       base_addr,
   input  logic [7:0]                  scale_w,
   input  logic [7:0]                  scale_a,
   output logic                        rd_en,
   output logic [ADDR_WIDTH-1:0]       rd_addr,
   input  logic [3:0]                  buf_w,
   input  logic [3:0]                  buf_a,
   output logic                        mac_en,
   output logic                        mac_clr,
   output logic [3:0]                  mac_w,
   output logic [3:0]                  mac_a,
   input  logic signed [ACC_WIDTH-1:0] mac_out,
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic signed [ACC_WIDTH-1:0] res_acc,
   output logic signed [9:0]           res_exp,
   output logic                        res_nan,
   output logic                        busy
);

   localparam int LW = ADDR_WIDTH + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_ISSUE,
      S_WAIT,
      S_FLUSH,
      S_RESULT
   } state_t;

   state_t                state, state_next;
   logic [LW-1:0]         len_q;
   logic [LW-1:0]         cnt;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [7:0]            scale_w_q;
   logic [7:0]            scale_a_q;
   logic                  en_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         len_q     <= '0;
         cnt       <= '0;
         base_q    <= '0;
         scale_w_q <= '0;
         scale_a_q <= '0;
         en_d      <= 1'b0;
      end else begin
         state <= state_next;
         en_d  <= rd_en;
         if (state == S_IDLE && start_valid) begin
            len_q     <= len;
            base_q    <= base_addr;
            scale_w_q <= scale_w;
            scale_a_q <= scale_a;
         end
         if (state == S_CLEAR)
            cnt <= '0;
         else if (state == S_ISSUE)
            cnt <= cnt + LW'(1);
      end
   end

   always_comb begin
      state_next  = state;
      start_ready = 1'b0;
      rd_en       = 1'b0;
      rd_addr     = '0;
      mac_en      = en_d;
      mac_clr     = reset;
      mac_w       = en_d ? buf_w : 4'd0;
      mac_a       = en_d ? buf_a : 4'd0;
      res_valid   = 1'b0;
      res_acc     = '0;
      res_exp     = '0;
      res_nan     = 1'b0;
      busy        = (state != S_IDLE);
      unique case (state)
         S_IDLE: begin
            start_ready = 1'b1;
            if (start_valid) state_next = S_CLEAR;
         end
         S_CLEAR: begin
            mac_clr    = 1'b1;
            state_next = (len_q == '0) ? S_RESULT : S_ISSUE;
         end
         S_ISSUE: begin
            rd_en   = 1'b1;
            rd_addr = base_q + cnt[ADDR_WIDTH-1:0];
            if (cnt == len_q - LW'(1)) state_next = S_WAIT;
         end
         S_WAIT: state_next = S_FLUSH;
         S_FLUSH: begin
            mac_en     = 1'b1;
            mac_w      = 4'd0;
            mac_a      = 4'd0;
            state_next = S_RESULT;
         end
         S_RESULT: begin
            // MAC sees no enable here, so mac_out is stable for the whole hold
            res_valid = 1'b1;
            res_acc   = mac_out;
            res_exp   = 10'(scale_w_q) + 10'(scale_a_q) - 10'd254;
            res_nan   = (scale_w_q == 8'hFF) | (scale_a_q == 8'hFF);
            if (res_ready) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mxfp4_dot_ctrl.sv
// Self-checking bench for mxfp4_dot_ctrl with a behavioural buffer and MAC lane;
// expected results come from real-valued fp4 arithmetic.
module tb_mxfp4_dot_ctrl;

   logic               clk = 1'b0;
   logic               reset;
   logic               start_valid;
   logic               start_ready;
   logic [6:0]         len;
   logic [5:0]         base_addr;
   logic [7:0]         scale_w, scale_a;
   logic               rd_en;
   logic [5:0]         rd_addr;
   logic [3:0]         buf_w, buf_a;
   logic               mac_en, mac_clr;
   logic [3:0]         mac_w, mac_a;
   logic signed [13:0] mac_out;
   logic               res_valid, res_ready;
   logic signed [13:0] res_acc;
   logic signed [9:0]  res_exp;
   logic               res_nan;
   logic               busy;

   int tests = 0;
   int fails = 0;

   logic [3:0] mem_w [64];
   logic [3:0] mem_a [64];

   always #5 clk = ~clk;

   mxfp4_dot_ctrl #(.ADDR_WIDTH(6), .ACC_WIDTH(14)) dut (
      .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
      .len(len), .base_addr(base_addr), .scale_w(scale_w), .scale_a(scale_a),
      .rd_en(rd_en), .rd_addr(rd_addr), .buf_w(buf_w), .buf_a(buf_a),
      .mac_en(mac_en), .mac_clr(mac_clr), .mac_w(mac_w), .mac_a(mac_a),
      .mac_out(mac_out), .res_valid(res_valid), .res_ready(res_ready),
      .res_acc(res_acc), .res_exp(res_exp), .res_nan(res_nan), .busy(busy)
   );

   // fp4 E2M1 value as a real number
   function automatic real fp4_real(logic [3:0] v);
      int  e = int'(v[2:1]);
      int  m = int'(v[0]);
      real mag;
      if (e == 0) mag = 0.5 * m;
      else        mag = (1.0 + 0.5 * m) * real'(1 << e) / 2.0;
      return v[3] ? -mag : mag;
   endfunction

   function automatic int wrap14(int v);
      logic [13:0] t = v[13:0];
      return int'($signed(t));
   endfunction

   // operand buffer: one-cycle read latency
   always @(posedge clk)
      if (rd_en) begin
         buf_w <= mem_w[rd_addr];
         buf_a <= mem_a[rd_addr];
      end

   // MAC lane: registered product, then accumulate; integer unit is 0.25
   int prod_q, acc_q;
   always @(posedge clk)
      if (mac_clr) begin
         prod_q <= 0;
         acc_q  <= 0;
      end else if (mac_en) begin
         prod_q <= int'(fp4_real(mac_w) * fp4_real(mac_a) * 4.0);
         acc_q  <= wrap14(acc_q + prod_q);
      end
   assign mac_out = 14'(acc_q);

   task automatic fill(int base, int n, int fw, int fa);
      for (int i = 0; i < n; i++) begin
         mem_w[(base + i) % 64] = (fw < 0) ? 4'($urandom_range(0, 15)) : 4'(fw);
         mem_a[(base + i) % 64] = (fa < 0) ? 4'($urandom_range(0, 15)) : 4'(fa);
      end
   endtask

   // Runs one job from an idle negedge; returns the accumulator observed on the result port.
   task automatic run_job(input string tag, input int n, input int base, input logic [7:0] sw,
                          input logic [7:0] sa, input int hold, output int got_acc);
      real               s = 0.0;
      int                exp_acc, rv_k, mac_cnt, exp_mac;
      logic signed [9:0] exp_exp;
      logic              exp_nan, exp_rd, exp_clr;
      logic signed [13:0] held;
      for (int i = 0; i < n; i++)
         s += fp4_real(mem_w[(base + i) % 64]) * fp4_real(mem_a[(base + i) % 64]);
      exp_acc = wrap14(int'(s * 4.0));
      exp_exp = 10'(int'(sw) + int'(sa) - 254);
      exp_nan = (sw == 8'hFF) || (sa == 8'hFF);
      rv_k    = (n == 0) ? 2 : n + 4;
      exp_mac = (n == 0) ? 0 : n + 1;
      got_acc = 0;

      tests++;
      if (start_ready !== 1'b1) begin
         fails++; $display("FAIL %s start_ready got %b exp 1", tag, start_ready);
      end
      start_valid = 1'b1; len = 7'(n); base_addr = 6'(base);
      scale_w = sw; scale_a = sa; res_ready = 1'b0;
      @(negedge clk);
      start_valid = 1'b0;
      mac_cnt = 0;
      for (int k = 1; k < rv_k; k++) begin
         exp_rd  = (k >= 2) && (k <= n + 1);
         exp_clr = (k == 1);
         tests++;
         if (rd_en !== exp_rd || (exp_rd && rd_addr !== 6'((base + k - 2) % 64))) begin
            fails++;
            $display("FAIL %s rd k=%0d got en=%b addr=%0d exp en=%b addr=%0d",
                     tag, k, rd_en, rd_addr, exp_rd, (base + k - 2) % 64);
         end
         tests++;
         if (mac_clr !== exp_clr || res_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s ctl k=%0d got clr=%b rv=%b exp clr=%b rv=0",
                     tag, k, mac_clr, res_valid, exp_clr);
         end
         if (mac_en === 1'b1) mac_cnt++;
         @(negedge clk);
      end
      tests++;
      if (mac_cnt != exp_mac) begin
         fails++; $display("FAIL %s mac_en_cycles got %0d exp %0d", tag, mac_cnt, exp_mac);
      end
      tests++;
      if (res_valid !== 1'b1 || res_acc !== 14'(exp_acc)) begin
         fails++;
         $display("FAIL %s result got rv=%b acc=%0d exp rv=1 acc=%0d", tag, res_valid, res_acc, exp_acc);
      end
      tests++;
      if (res_exp !== exp_exp || res_nan !== exp_nan) begin
         fails++;
         $display("FAIL %s exp/nan got %0d/%b exp %0d/%b", tag, res_exp, res_nan, exp_exp, exp_nan);
      end
      got_acc = int'(res_acc);
      held = res_acc;
      for (int h = 0; h < hold; h++) begin
         start_valid = h[0];
         len = 7'd1;
         @(negedge clk);
         tests++;
         if (res_valid !== 1'b1 || res_acc !== held || start_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s hold h=%0d got rv=%b acc=%0d sr=%b exp rv=1 acc=%0d sr=0",
                     tag, h, res_valid, res_acc, start_ready, held);
         end
      end
      start_valid = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      tests++;
      if (res_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL %s after_handshake got rv=%b sr=%b busy=%b exp 0/1/0",
                  tag, res_valid, start_ready, busy);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start_valid = 1'b0; res_ready = 1'b0;
      len = '0; base_addr = '0; scale_w = '0; scale_a = '0;
      repeat (3) @(negedge clk);
      tests++;
      if (start_ready !== 1'b1 || busy !== 1'b0 || rd_en !== 1'b0 || mac_en !== 1'b0 ||
          mac_clr !== 1'b1 || res_valid !== 1'b0 || res_acc !== 14'sd0 ||
          res_exp !== 10'sd0 || res_nan !== 1'b0 || mac_w !== 4'd0 || mac_a !== 4'd0) begin
         fails++;
         $display("FAIL reset_state got sr=%b busy=%b rd=%b men=%b clr=%b rv=%b acc=%0d exp=%0d nan=%b",
                  start_ready, busy, rd_en, mac_en, mac_clr, res_valid, res_acc, res_exp, res_nan);
      end
      reset = 1'b0;
      @(negedge clk);
      tests++;
      if (mac_clr !== 1'b0) begin
         fails++; $display("FAIL reset_release mac_clr got %b exp 0", mac_clr);
      end
   endtask

   task automatic test_basic();
      int acc;
      fill(0, 4, 3, 3);
      run_job("basic", 4, 0, 8'd127, 8'd127, 0, acc);
      tests++;
      if (acc != 36) begin fails++; $display("FAIL basic_value got %0d exp 36", acc); end
   endtask

   task automatic test_wrap();
      int acc;
      fill(62, 4, 4'hB, 4'h3);
      run_job("wrap", 4, 62, 8'd130, 8'd120, 0, acc);
      tests++;
      if (acc != -36) begin fails++; $display("FAIL wrap_value got %0d exp -36", acc); end
   endtask

   task automatic test_long();
      int acc;
      fill(5, 32, 7, 7);
      run_job("long", 32, 5, 8'd127, 8'd127, 0, acc);
      tests++;
      if (acc != 4608) begin fails++; $display("FAIL long_value got %0d exp 4608", acc); end
   endtask

   task automatic test_zero_nan();
      int acc;
      run_job("zero_nan", 0, 17, 8'hFF, 8'd3, 0, acc);
      tests++;
      if (acc != 0) begin fails++; $display("FAIL zero_value got %0d exp 0", acc); end
   endtask

   task automatic test_backpressure();
      int acc;
      fill(40, 6, -1, -1);
      run_job("backpressure", 6, 40, 8'd100, 8'd200, 10, acc);
   endtask

   task automatic test_reset_midjob();
      int acc, rises;
      fill(10, 8, 7, 7);
      start_valid = 1'b1; len = 7'd8; base_addr = 6'd10;
      scale_w = 8'd127; scale_a = 8'd127; res_ready = 1'b1;
      @(negedge clk);
      start_valid = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if (rd_en !== 1'b1 || rd_addr !== 6'd12) begin
         fails++; $display("FAIL midjob_issue got en=%b addr=%0d exp en=1 addr=12", rd_en, rd_addr);
      end
      reset = 1'b1;
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || start_ready !== 1'b1 || mac_clr !== 1'b1 || rd_en !== 1'b0 || mac_en !== 1'b0) begin
         fails++;
         $display("FAIL midjob_abort got busy=%b sr=%b clr=%b rd=%b men=%b exp 0/1/1/0/0",
                  busy, start_ready, mac_clr, rd_en, mac_en);
      end
      reset = 1'b0;
      rises = 0;
      for (int i = 0; i < 15; i++) begin
         if (res_valid !== 1'b0 || busy !== 1'b0) rises++;
         @(negedge clk);
      end
      res_ready = 1'b0;
      tests++;
      if (rises != 0) begin fails++; $display("FAIL midjob_no_result got %0d active cycles exp 0", rises); end
      fill(20, 1, 2, 2);
      run_job("after_reset", 1, 20, 8'd127, 8'd127, 0, acc);
      tests++;
      if (acc != 4) begin fails++; $display("FAIL after_reset_value got %0d exp 4", acc); end
   endtask

   task automatic test_back_to_back();
      int acc, n, base, hold;
      for (int j = 0; j < 8; j++) begin
         n    = $urandom_range(0, 24);
         base = $urandom_range(0, 63);
         hold = (j % 2 == 0) ? 0 : $urandom_range(1, 3);
         fill(base, n, -1, -1);
         run_job($sformatf("rand%0d", j), n, base, 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), hold, acc);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_long();
      test_zero_nan();
      test_backpressure();
      test_reset_midjob();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
